// File: rtl/booth_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier that time-shares one 4x4 Booth core over four nibble steps.
// Optional zero-operand bypass is enabled by defining BOOTH_SEQ_EARLY_EXIT_EN.

module booth4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  logic [6:0] bx;
  logic [2:0] grp;
  logic [7:0] pp;
  logic [7:0] acc;

  // Radix-4 recoding of zero-extended b; arithmetic mod 2^8 is exact since a*b < 256.
  always_comb begin
    bx  = {2'b00, b, 1'b0};
    acc = 8'd0;
    grp = 3'd0;
    pp  = 8'd0;
    for (int i = 0; i < 3; i++) begin
      grp = bx[2*i +: 3];
      case (grp)
        3'b001, 3'b010: pp = {4'b0000, a};
        3'b011:         pp = {3'b000, a, 1'b0};
        3'b100:         pp = 8'd0 - {3'b000, a, 1'b0};
        3'b101, 3'b110: pp = 8'd0 - {4'b0000, a};
        default:        pp = 8'd0;
      endcase
      acc = acc + (pp << (2 * i));
    end
    p = acc;
  end
endmodule

module booth_seq_ctrl (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] Z
);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state;
  logic [1:0]  step;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] acc;
  logic [3:0]  nib_a;
  logic [3:0]  nib_b;
  logic [7:0]  pp;
  logic [15:0] pp_shift;
  logic [15:0] sum;
  logic        accept;
  logic        zero_op;

  booth4 u_booth4 (.a(nib_a), .b(nib_b), .p(pp));

  always_comb begin
    nib_a = step[1] ? a_q[7:4] : a_q[3:0];
    nib_b = step[0] ? b_q[7:4] : b_q[3:0];
    case (step)
      2'd0:    pp_shift = {8'd0, pp};
      2'd3:    pp_shift = {pp, 8'd0};
      default: pp_shift = {4'd0, pp, 4'd0};
    endcase
    sum    = acc + pp_shift;
    accept = Start && (state == IDLE || state == DONE);
`ifdef BOOTH_SEQ_EARLY_EXIT_EN
    zero_op = (A == 8'd0) || (B == 8'd0);
`else
    zero_op = 1'b0;
`endif
  end

  // A zero operand jumps straight to the last step: AH*BH is then zero, so Z lands as 0 one edge later.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      step  <= 2'd0;
      acc   <= 16'd0;
      a_q   <= 8'd0;
      b_q   <= 8'd0;
      Z     <= 16'h0000;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          Done <= 1'b0;
          if (accept) begin
            a_q   <= A;
            b_q   <= B;
            acc   <= 16'd0;
            step  <= zero_op ? 2'd3 : 2'd0;
            Busy  <= !zero_op;
            state <= MUL;
          end else begin
            state <= IDLE;
          end
        end
        MUL: begin
          acc  <= sum;
          step <= step + 2'd1;
          if (step == 2'd3) begin
            Z     <= sum;
            Done  <= 1'b1;
            Busy  <= 1'b0;
            acc   <= 16'd0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Scoreboard bench for booth_seq_ctrl: stimulus pushes expected result, completion cycle and busy length.
`timescale 1ns/1ps

module tb_booth_seq_ctrl;
  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        Busy;
  logic        Done;
  logic [15:0] Z;

  typedef struct {
    logic [15:0] z;
    int          cyc;
    int          busy;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   cyc = 0;
  int   busy_run = 0;
  int   vectors = 0;
  int   miscompares = 0;

`ifdef BOOTH_SEQ_EARLY_EXIT_EN
  localparam int ZLAT = 2;
  localparam int ZBUSY = 0;
`else
  localparam int ZLAT = 5;
  localparam int ZBUSY = 4;
`endif

  booth_seq_ctrl dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .A(A), .B(B),
    .Busy(Busy), .Done(Done), .Z(Z)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  // Called at 1ns after a rising edge; acceptance happens on the next edge.
  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] z,
                    input int lat, input int bl);
    exp_t e;
    A = a;
    B = b;
    Start = 1'b1;
    e.z = z;
    e.cyc = cyc + lat;
    e.busy = bl;
    sb.push_back(e);
    wait_cyc(1);
    Start = 1'b0;
  endtask

  always @(negedge Clk) begin
    chk("busy_done_exclusive", {31'd0, Busy & Done}, 32'd0);
    if (Done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got Z=%h with no result pending (cycle %0d)", Z, cyc);
      end else begin
        e_mon = sb.pop_front();
        chk("result_z", {16'd0, Z}, {16'd0, e_mon.z});
        chk("done_cycle", cyc, e_mon.cyc);
        chk("busy_length", busy_run, e_mon.busy);
      end
      busy_run = 0;
    end else if (Busy) begin
      busy_run++;
    end else begin
      busy_run = 0;
    end
  end

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    A = 8'h00;
    B = 8'h00;
    wait_cyc(2);
    Reset = 1'b0;
    repeat (3) begin
      wait_cyc(1);
      chk("reset_z", {16'd0, Z}, 32'h0000);
      chk("reset_busy", {31'd0, Busy}, 32'd0);
      chk("reset_done", {31'd0, Done}, 32'd0);
    end

    op(8'h12, 8'h34, 16'h03A8, 5, 4);
    wait_cyc(6);
    chk("z_hold", {16'd0, Z}, 32'h03A8);

    // back-to-back: Start held while Done is high
    op(8'hFF, 8'hFF, 16'hFE01, 5, 4);
    wait_cyc(4);
    chk("done_before_b2b", {31'd0, Done}, 32'd1);
    op(8'h0F, 8'h10, 16'h00F0, 5, 4);
    chk("b2b_busy_rises", {31'd0, Busy}, 32'd1);
    chk("b2b_done_drops", {31'd0, Done}, 32'd0);
    wait_cyc(6);

    // request during MUL must be ignored
    op(8'h05, 8'h07, 16'h0023, 5, 4);
    A = 8'hFF;
    B = 8'hFF;
    Start = 1'b1;
    wait_cyc(1);
    Start = 1'b0;
    wait_cyc(8);

    // abort on the second MUL cycle
    A = 8'hAA;
    B = 8'h55;
    Start = 1'b1;
    wait_cyc(1);
    Start = 1'b0;
    wait_cyc(1);
    Reset = 1'b1;
    wait_cyc(1);
    Reset = 1'b0;
    chk("abort_z", {16'd0, Z}, 32'h0000);
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_done", {31'd0, Done}, 32'd0);
    wait_cyc(6);
    op(8'h03, 8'h04, 16'h000C, 5, 4);
    wait_cyc(6);

    op(8'h00, 8'h9C, 16'h0000, ZLAT, ZBUSY);
    wait_cyc(6);
    op(8'h5A, 8'h00, 16'h0000, ZLAT, ZBUSY);
    wait_cyc(6);
    op(8'hAB, 8'hCD, 16'h88EF, 5, 4);
    wait_cyc(6);
    op(8'h80, 8'h02, 16'h0100, 5, 4);

    for (int i = 0; i < 50 && sb.size() > 0; i++) wait_cyc(1);
    wait_cyc(2);
    while (sb.size() > 0) begin
      e_mon = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_done: got no Done expected Z=%h by cycle %0d", e_mon.z, e_mon.cyc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
